instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style core: reset vector, fetch FSM states,
// and the decoder's instruction-type / ALU-code constants.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int unsigned WORD_BYTES       = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'b00,
    FETCH_BUSY  = 2'b01,
    FETCH_HOLD  = 2'b10
  } fetch_state_t;

  // Instruction-type codes produced by the decoder from the IR opcode field.
  localparam logic [2:0] INST_TYPE_R      = 3'd0;
  localparam logic [2:0] INST_TYPE_I      = 3'd1;
  localparam logic [2:0] INST_TYPE_LOAD   = 3'd2;
  localparam logic [2:0] INST_TYPE_STORE  = 3'd3;
  localparam logic [2:0] INST_TYPE_BRANCH = 3'd4;
  localparam logic [2:0] INST_TYPE_JUMP   = 3'd5;
  localparam logic [2:0] INST_TYPE_OTHER  = 3'd7;

  localparam logic [3:0] ALUCODE_ADD  = 4'd0;
  localparam logic [3:0] ALUCODE_SUB  = 4'd1;
  localparam logic [3:0] ALUCODE_AND  = 4'd2;
  localparam logic [3:0] ALUCODE_OR   = 4'd3;
  localparam logic [3:0] ALUCODE_XOR  = 4'd4;
  localparam logic [3:0] ALUCODE_NOR  = 4'd5;
  localparam logic [3:0] ALUCODE_SLT  = 4'd6;
  localparam logic [3:0] ALUCODE_SLTU = 4'd7;
  localparam logic [3:0] ALUCODE_SLL  = 4'd8;
  localparam logic [3:0] ALUCODE_SRL  = 4'd9;
  localparam logic [3:0] ALUCODE_SRA  = 4'd10;
  localparam logic [3:0] ALUCODE_LUI  = 4'd11;

  function automatic logic isWordAligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, instruction register and a small
// request/acknowledge FSM talking to the instruction memory.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_stateNext;
  logic         w_accept;
  logic         w_misalign;
  logic         w_done;

  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic         r_irValid;
  logic [31:0]  r_addr;
  logic         r_err;
  logic [31:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH_IDLE;
    else     r_state <= w_stateNext;
  end

  // fetch_start is only honoured outside FETCH; a misaligned PC flags an error
  // and leaves the FSM where it is.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_misalign  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      FETCH_IDLE, FETCH_HOLD: begin
        if (fetch_start) begin
          if (isWordAligned(r_pc)) begin
            w_accept    = 1'b1;
            w_stateNext = FETCH_BUSY;
          end else begin
            w_misalign  = 1'b1;
          end
        end
      end
      FETCH_BUSY: begin
        if (imem_ack) begin
          w_done      = 1'b1;
          w_stateNext = FETCH_HOLD;
        end
      end
      default: w_stateNext = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'h0;
      r_irValid <= 1'b0;
      r_addr    <= 32'h0;
      r_err     <= 1'b0;
      r_cnt     <= 32'h0;
    end else begin
      r_err <= w_misalign;
      if (w_accept) begin
        r_addr    <= r_pc;
        r_irValid <= 1'b0;
      end
      if (w_done) begin
        r_ir      <= imem_rdata;
        r_irValid <= 1'b1;
        r_cnt     <= r_cnt + 32'd1;
      end
      // The fetch above already captured the pre-update PC.
      if (pc_we) r_pc <= pc_next;
    end
  end

  assign imem_req  = (r_state == FETCH_BUSY);
  assign busy      = (r_state == FETCH_BUSY);
  assign imem_addr = r_addr;
  assign ir        = r_ir;
  assign ir_valid  = r_irValid;
  assign pc        = r_pc;
  assign pc_plus4  = r_pc + 32'd4;
  assign fetch_err = r_err;
  assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch, checked cycle by cycle
// against a transaction-level model of the fetch unit.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_we = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_start(fetch_start),
    .pc_we      (pc_we),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: one outstanding read at most, tracked as a flag.
  logic [31:0] mPc;
  logic [31:0] mIr;
  logic        mIrValid;
  logic        mOutstanding;
  logic [31:0] mAddr;
  logic        mErr;
  logic [31:0] mCnt;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic modelStep(input bit s, input bit we, input logic [31:0] nxt,
                           input bit ack, input logic [31:0] rd, input bit r);
    if (r) begin
      mPc = 32'h0040_0000; mIr = 32'h0; mIrValid = 1'b0;
      mOutstanding = 1'b0; mAddr = 32'h0; mErr = 1'b0; mCnt = 32'h0;
    end else begin
      mErr = 1'b0;
      if (mOutstanding) begin
        if (ack) begin
          mIr = rd; mIrValid = 1'b1; mOutstanding = 1'b0; mCnt = mCnt + 32'd1;
        end
      end else if (s) begin
        if (mPc % 4 == 0) begin
          mAddr = mPc; mOutstanding = 1'b1; mIrValid = 1'b0;
        end else begin
          mErr = 1'b1;
        end
      end
      if (we) mPc = nxt;
    end
  endtask

  task automatic checkOutput();
    checkVal("pc",        pc,        mPc);
    checkVal("pc_plus4",  pc_plus4,  mPc + 32'd4);
    checkVal("ir",        ir,        mIr);
    checkVal("ir_valid",  {31'b0, ir_valid},  {31'b0, mIrValid});
    checkVal("imem_req",  {31'b0, imem_req},  {31'b0, mOutstanding});
    checkVal("busy",      {31'b0, busy},      {31'b0, mOutstanding});
    checkVal("imem_addr", imem_addr, mAddr);
    checkVal("fetch_err", {31'b0, fetch_err}, {31'b0, mErr});
    checkVal("fetch_cnt", fetch_cnt, mCnt);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input bit s, input bit we, input logic [31:0] nxt,
                               input bit ack, input logic [31:0] rd, input bit r);
    fetch_start = s; pc_we = we; pc_next = nxt;
    imem_ack = ack; imem_rdata = rd; rst = r;
    @(posedge clk);
    modelStep(s, we, nxt, ack, rd, r);
    #1;
    checkOutput();
  endtask

  logic [31:0] rndA;
  logic [31:0] rndB;
  logic [31:0] addrSnap;

  initial begin
    mPc = 32'h0; mIr = 32'h0; mIrValid = 1'b0; mOutstanding = 1'b0;
    mAddr = 32'h0; mErr = 1'b0; mCnt = 32'h0;

    // Reset for two cycles.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkVal("reset_pc",       pc,       32'h0040_0000);
    checkVal("reset_pc_plus4", pc_plus4, 32'h0040_0004);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Zero-wait fetch.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("zw_req_n1", {31'b0, imem_req}, 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h2008_0005, 0);
    checkVal("zw_ir",  ir,        32'h2008_0005);
    checkVal("zw_cnt", fetch_cnt, 32'd1);

    // Three-cycle wait with redundant fetch_start while busy.
    applyStimulus(1, 0, 0, 0, 0, 0);
    addrSnap = imem_addr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 32'hDEAD_BEEF, 0);
      checkVal("wait_addr_stable", imem_addr, addrSnap);
    end
    applyStimulus(0, 0, 0, 1, 32'h8C09_0004, 0);
    checkVal("wait_ir", ir, 32'h8C09_0004);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Misaligned PC.
    applyStimulus(0, 1, 32'h0040_0002, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("mis_err", {31'b0, fetch_err}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("mis_err_clear", {31'b0, fetch_err}, 32'd0);

    // PC write during an outstanding fetch, and coincident with fetch_start.
    applyStimulus(1, 1, 32'h0040_0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0040_0100, 0, 0, 0);
    checkVal("mid_pc",   pc,        32'h0040_0100);
    checkVal("mid_addr", imem_addr, 32'h0040_0000);
    applyStimulus(0, 0, 0, 1, 32'h0000_0020, 0);

    // Reset while fetching; the late ack must be discarded.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 32'h1234_5678, 0);
    applyStimulus(0, 0, 0, 1, 32'h1234_5678, 0);
    checkVal("rstmid_ir",  ir,        32'h0);
    checkVal("rstmid_cnt", fetch_cnt, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rndA = $urandom;
      rndB = $urandom;
      if (rndA[2:0] != 3'd0) rndB[1:0] = 2'b00;
      applyStimulus(rndA[4:3] != 2'b00, rndA[8:6] == 3'd0, rndB,
                    rndA[10:9] != 2'b00, $urandom, rndA[17:12] == 6'd0);
    end

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
